// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters,
// with a one-entry registered response slot and per-port accepted-operation counters.
module alu_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic [2:0]           req0_op,

  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  input  logic [2:0]           req1_op,

  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_ctrl,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_n,
  input  logic                 alu_z,
  input  logic                 alu_v,
  input  logic                 alu_c,

  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_n,
  output logic                 rsp_z,
  output logic                 rsp_v,
  output logic                 rsp_c,

  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic free;
  logic any_valid;
  logic chosen;
  logic accept;
  logic last_grant;

  // A response drained this cycle frees the slot for a same-cycle accept.
  always_comb begin
    free      = !rsp_valid || rsp_ready;
    any_valid = req0_valid || req1_valid;
    if (req0_valid && req1_valid) begin
      chosen = ~last_grant;
    end else begin
      chosen = req1_valid;
    end
    accept     = free && any_valid;
    req0_ready = accept && !chosen;
    req1_ready = accept && chosen;
  end

  // Idle cycles fall through to port 0 so the ALU inputs stay deterministic.
  always_comb begin
    if (any_valid && chosen) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_ctrl = req1_op;
    end else begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      alu_ctrl = req0_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_n      <= 1'b0;
      rsp_z      <= 1'b0;
      rsp_v      <= 1'b0;
      rsp_c      <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= chosen;
      rsp_result <= alu_out;
      rsp_n      <= alu_n;
      rsp_z      <= alu_z;
      rsp_v      <= alu_v;
      rsp_c      <= alu_c;
      last_grant <= chosen;
      if (chosen) begin
        cnt1 <= cnt1 + CntOne;
      end else begin
        cnt0 <= cnt0 + CntOne;
      end
    end else if (rsp_ready) begin
      // Drain only; payload registers keep their last values.
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, hand-written corner sequences and
// constrained-random traffic against a transaction-level reference model.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0, rr = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [2:0] op0 = '0, op1 = '0;

  logic       r0, r1;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_ctrl;
  logic       alu_n, alu_z, alu_v, alu_c;
  logic       rsp_valid, rsp_id, rsp_n, rsp_z, rsp_v, rsp_c;
  logic [7:0] rsp_result;
  logic [15:0] cnt0, cnt1;

  // Narrow-counter instance fed the same traffic, used for wrap checks.
  logic       r0_w, r1_w;
  logic [7:0] alu_a_w, alu_b_w, alu_out_w;
  logic [2:0] alu_ctrl_w;
  logic       alu_n_w, alu_z_w, alu_v_w, alu_c_w;
  logic       rsp_valid_w, rsp_id_w, rsp_n_w, rsp_z_w, rsp_v_w, rsp_c_w;
  logic [7:0] rsp_result_w;
  logic [1:0] cnt0_w, cnt1_w;

  always #5 clk = ~clk;

  // Bench ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR. Returns {n,z,v,c,r}.
  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 9'd1;
        r = s[7:0];
        c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin
        r = {a[6:0], 1'b0};
        c = a[7];
      end
      default: begin
        r = {1'b0, a[7:1]};
        c = a[0];
      end
    endcase
    return {r[7], (r == 8'd0), v, c, r};
  endfunction

  assign {alu_n, alu_z, alu_v, alu_c, alu_out} = alu_f(alu_a, alu_b, alu_ctrl);
  assign {alu_n_w, alu_z_w, alu_v_w, alu_c_w, alu_out_w} = alu_f(alu_a_w, alu_b_w, alu_ctrl_w);

  alu_arbiter #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_op(op0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_op(op1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rr), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_n(rsp_n), .rsp_z(rsp_z), .rsp_v(rsp_v), .rsp_c(rsp_c),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  alu_arbiter #(.WIDTH(8), .CNT_WIDTH(2)) dut_w (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0_w), .req0_a(a0), .req0_b(b0), .req0_op(op0),
    .req1_valid(v1), .req1_ready(r1_w), .req1_a(a1), .req1_b(b1), .req1_op(op1),
    .alu_a(alu_a_w), .alu_b(alu_b_w), .alu_ctrl(alu_ctrl_w), .alu_out(alu_out_w),
    .alu_n(alu_n_w), .alu_z(alu_z_w), .alu_v(alu_v_w), .alu_c(alu_c_w),
    .rsp_valid(rsp_valid_w), .rsp_ready(rr), .rsp_id(rsp_id_w), .rsp_result(rsp_result_w),
    .rsp_n(rsp_n_w), .rsp_z(rsp_z_w), .rsp_v(rsp_v_w), .rsp_c(rsp_c_w),
    .cnt0(cnt0_w), .cnt1(cnt1_w)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot contents, who went last, and accept counts as plain integers.
  logic       m_full = 1'b0, m_id = 1'b0, m_last = 1'b1;
  logic [7:0] m_res = '0;
  logic [3:0] m_flags = '0;
  int         m_cnt[2] = '{0, 0};
  logic       seen_r0, seen_r1;

  // One clock: check readies/ALU mux mid-cycle, advance model, check registered outputs.
  task automatic cycle();
    logic        any, w, free;
    logic [11:0] f;
    @(negedge clk);
    seen_r0 = r0;
    seen_r1 = r1;
    if (rst) begin
      m_full = 1'b0; m_id = 1'b0; m_last = 1'b1; m_res = '0; m_flags = '0;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      any  = v0 || v1;
      w    = (v0 && v1) ? !m_last : v1;
      free = !m_full || rr;
      chk("req0_ready", {31'b0, r0}, {31'b0, free && any && !w});
      chk("req1_ready", {31'b0, r1}, {31'b0, free && any && w});
      chk("alu_a", {24'b0, alu_a}, {24'b0, (any && w) ? a1 : a0});
      chk("alu_ctrl", {29'b0, alu_ctrl}, {29'b0, (any && w) ? op1 : op0});
      if (free && any) begin
        f = w ? alu_f(a1, b1, op1) : alu_f(a0, b0, op0);
        m_full = 1'b1; m_id = w; m_last = w;
        m_res = f[7:0]; m_flags = f[11:8];
        m_cnt[w] = m_cnt[w] + 1;
      end else if (m_full && rr) begin
        m_full = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_full});
    chk("rsp_id", {31'b0, rsp_id}, {31'b0, m_id});
    chk("rsp_result", {24'b0, rsp_result}, {24'b0, m_res});
    chk("rsp_flags", {28'b0, rsp_n, rsp_z, rsp_v, rsp_c}, {28'b0, m_flags});
    chk("cnt0", {16'b0, cnt0}, m_cnt[0] % 65536);
    chk("cnt1", {16'b0, cnt1}, m_cnt[1] % 65536);
    chk("cnt0_narrow", {30'b0, cnt0_w}, m_cnt[0] % 4);
    chk("cnt1_narrow", {30'b0, cnt1_w}, m_cnt[1] % 4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic       v0;
    logic [7:0] a0, b0;
    logic [2:0] op0;
    logic       v1;
    logic [7:0] a1, b1;
    logic [2:0] op1;
    logic       rr;
    logic       er0, er1, erv, eid;
    logic [7:0] eres;
    logic [3:0] eflags;
    logic [15:0] ec0, ec1;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] held;

    vecs[0] = '{1'b1, 8'h05, 8'h03, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b0, 8'h08, 4'b0000, 16'd1, 16'd0};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'h7F, 8'h01, 3'd0, 1'b1,
                1'b0, 1'b1, 1'b1, 1'b1, 8'h80, 4'b1010, 16'd1, 16'd1};
    vecs[2] = '{1'b1, 8'hFF, 8'h01, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0,
                1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 4'b1010, 16'd1, 16'd1};
    vecs[3] = '{1'b1, 8'hFF, 8'h01, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0101, 16'd2, 16'd1};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0101, 16'd2, 16'd1};
    vecs[5] = '{1'b1, 8'h10, 8'h20, 3'd1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0,
                1'b1, 1'b0, 1'b1, 1'b0, 8'hF0, 4'b1000, 16'd3, 16'd1};
    vecs[6] = '{1'b1, 8'h03, 8'h03, 3'd4, 1'b1, 8'h01, 8'h02, 3'd3, 1'b1,
                1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 4'b0000, 16'd3, 16'd2};
    vecs[7] = '{1'b1, 8'h03, 8'h03, 3'd4, 1'b1, 8'h01, 8'h02, 3'd3, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0100, 16'd4, 16'd2};

    // Reset state.
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset rsp_result", {24'b0, rsp_result}, 32'd0);
    chk("reset cnt0", {16'b0, cnt0}, 32'd0);

    // Directed table.
    foreach (vecs[i]) begin
      {v0, a0, b0, op0, v1, a1, b1, op1, rr} = {vecs[i].v0, vecs[i].a0, vecs[i].b0,
        vecs[i].op0, vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].op1, vecs[i].rr};
      cycle();
      chk($sformatf("vec%0d r0", i), {31'b0, seen_r0}, {31'b0, vecs[i].er0});
      chk($sformatf("vec%0d r1", i), {31'b0, seen_r1}, {31'b0, vecs[i].er1});
      chk($sformatf("vec%0d rsp_valid", i), {31'b0, rsp_valid}, {31'b0, vecs[i].erv});
      chk($sformatf("vec%0d rsp_id", i), {31'b0, rsp_id}, {31'b0, vecs[i].eid});
      chk($sformatf("vec%0d result", i), {24'b0, rsp_result}, {24'b0, vecs[i].eres});
      chk($sformatf("vec%0d flags", i), {28'b0, rsp_n, rsp_z, rsp_v, rsp_c},
          {28'b0, vecs[i].eflags});
      chk($sformatf("vec%0d cnt0", i), {16'b0, cnt0}, {16'b0, vecs[i].ec0});
      chk($sformatf("vec%0d cnt1", i), {16'b0, cnt1}, {16'b0, vecs[i].ec1});
    end

    // Contention from reset alternates 0,1,0,1.
    v0 = 1'b0; v1 = 1'b0;
    do_reset();
    v0 = 1'b1; v1 = 1'b1; rr = 1'b1;
    a0 = 8'h11; b0 = 8'h22; op0 = 3'd0; a1 = 8'h33; b1 = 8'h44; op1 = 3'd2;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("contend%0d r0", i), {31'b0, seen_r0}, {31'b0, (i % 2) == 0});
      chk($sformatf("contend%0d id", i), {31'b0, rsp_id}, {31'b0, (i % 2) == 1});
    end
    chk("contend cnt0", {16'b0, cnt0}, 32'd2);
    chk("contend cnt1", {16'b0, cnt1}, 32'd2);

    // Backpressure: response held stable for 3 cycles, then port 1 wins on release.
    v1 = 1'b0;
    do_reset();
    v0 = 1'b1; a0 = 8'h05; b0 = 8'h03; op0 = 3'd0; rr = 1'b1;
    cycle();
    held = rsp_result;
    chk("bp first result", {24'b0, held}, 32'h08);
    v1 = 1'b1; rr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("bp%0d readies", i), {30'b0, seen_r0, seen_r1}, 32'd0);
      chk($sformatf("bp%0d held", i), {23'b0, rsp_valid, rsp_result}, {23'b0, 1'b1, held});
    end
    rr = 1'b1;
    cycle();
    chk("bp release r1", {31'b0, seen_r1}, 32'd1);
    chk("bp release id", {31'b0, rsp_id}, 32'd1);

    // Flag capture on port 1.
    v0 = 1'b0; v1 = 1'b1; a1 = 8'h7F; b1 = 8'h01; op1 = 3'd0;
    cycle();
    chk("flag result", {24'b0, rsp_result}, 32'h80);
    chk("flag nzvc", {28'b0, rsp_n, rsp_z, rsp_v, rsp_c}, 32'b1010);

    // Reset mid-operation with pending response and requests.
    v0 = 1'b1; v1 = 1'b1; rr = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst cnts", {cnt0, cnt1}, 32'd0);
    rr = 1'b1;
    cycle();
    chk("midrst first win", {31'b0, seen_r0}, 32'd1);

    // Narrow counter wrap: 1,2,3,0,1.
    v1 = 1'b0;
    do_reset();
    v0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk($sformatf("wrap%0d", i), {30'b0, cnt0_w}, (i + 1) % 4);
    end

    // Random traffic honouring the hold-until-ready rule.
    v0 = 1'b0; v1 = 1'b0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!(v0 && !seen_r0)) begin
        v0 = 1'($urandom_range(0, 1));
        a0 = 8'($urandom); b0 = 8'($urandom); op0 = 3'($urandom);
      end
      if (!(v1 && !seen_r1)) begin
        v1 = 1'($urandom_range(0, 1));
        a1 = 8'($urandom); b1 = 8'($urandom); op1 = 3'($urandom);
      end
      rr  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single execute-stage ALU between two requesters: port 0 is the pipeline execute path and port 1 is the auxiliary address/branch-target unit.
- Arbitrates round-robin and drives the ALU operand and control inputs. The ALU itself stays external and purely combinational.
- Captures the ALU result and flags into a one-entry registered response slot tagged with the winning requester's ID, held until the consumer accepts it.

Parameters:
- WIDTH, 8, data width of operands, result and ALU ports.
- CNT_WIDTH, 16, width of the per-port accepted-operation counters.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 has an operation.
- req0_ready  out  1  port 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  port 0 operands.
- req0_op  in  3  port 0 ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as port 0, for port 1.
- alu_a, alu_b  out  WIDTH  operands to ALU.
- alu_ctrl  out  3  control code to ALU.
- alu_out  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_ctrl).
- alu_n, alu_z, alu_v, alu_c  in  1  ALU flags.
- rsp_valid  out  1  response slot full.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  WIDTH  registered result.
- rsp_n, rsp_z, rsp_v, rsp_c  out  1  registered flags.
- cnt0, cnt1  out  CNT_WIDTH  accepted-operation count per port.

Behaviour:
- Reset values (synchronous):
  - rsp_valid=0, rsp_id=0, rsp_result=0, all rsp flags=0, cnt0=cnt1=0.
  - last_grant=1, so port 0 wins the first contention.
- Slot free (combinational): free = !rsp_valid || rsp_ready. A response drained in cycle T allows a new accept in the same cycle T, giving full throughput of 1 op/cycle.
- Arbitration (combinational, evaluated every cycle):
  - Only one valid request: that port is chosen.
  - Both valid: the port != last_grant is chosen.
  - Neither valid: nothing is chosen.
- reqN_ready = free && chosen==N. At most one ready is high per cycle. Ready may depend on valid.
- Accept = chosen port's valid && ready.
- On accept:
  - rsp_result, flags and rsp_id load from alu_* and the chosen index.
  - rsp_valid is set.
  - last_grant takes the chosen index.
  - The accepted port's counter increments.
- Drain without accept (rsp_valid && rsp_ready and no accept): rsp_valid clears. Data registers hold their last values.
- Stall (rsp_valid && !rsp_ready): both readies are 0 and all rsp_* outputs hold stable.
- Latency: response is visible exactly 1 cycle after accept.
- ALU mux:
  - alu_a/alu_b/alu_ctrl select the chosen port's operands.
  - With no request, they select port 0 inputs so the ALU stays deterministic.
  - last_grant changes only on accept.
- Counters wrap modulo 2^CNT_WIDTH with no saturation and no flag.
- Requesters must hold valid and payload stable until ready. The arbiter does not latch unaccepted requests.
- Reset mid-operation:
  - Any pending response is discarded and rsp_valid=0 on the next cycle.
  - The in-flight accept in the reset cycle is dropped; counters do not increment.
  - rst has priority over every other update.
- No combinational path from rsp_ready to rsp_* data. rsp_ready reaches the req*_ready outputs only through free.

Test Plan:
- Single op: req0 a=8'h05 b=8'h03 op=ADD, rsp_ready=1 -> req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=8'h08, Z=0, C=0; cnt0=1.
- Contention from reset: both valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1 on consecutive cycles; after 4 cycles cnt0=2 and cnt1=2.
- Backpressure: response pending with rsp_ready=0 for 3 cycles while both request -> both readies stay 0 and rsp_* stay constant; when rsp_ready rises, the next port in round-robin order is accepted that same cycle.
- Flag capture: req1 a=8'h7F b=8'h01 op=ADD -> rsp_id=1, result=8'h80, N=1, V=1, Z=0, C=0.
- Reset mid-operation: rst asserted while rsp_valid=1 and a request is pending -> next cycle rsp_valid=0, counters=0, no ready in the reset cycle is counted; first post-reset contention is won by port 0.
- Counter wrap with CNT_WIDTH=2: 5 accepts on port 0 -> cnt0 reads 1,2,3,0,1.
